// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Purpose  : N-digit multiplexed 7-segment scanner with hex font, DP/blank/
//            blink masks, leading-zero suppression, PWM dimming, anti-ghost.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int SCAN_DIV    = 65536,
    parameter int BLANK_CYC   = 256,
    parameter int PWM_BITS    = 4,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_i,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic                      blink_phase,
    input  logic                      lz_en,
    input  logic [PWM_BITS-1:0]       brightness,
    output logic [7:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic                      frame_tick
);

    localparam int                    c_CW      = $clog2(SCAN_DIV);
    localparam int                    c_IW      = $clog2(NUM_DIGITS);
    localparam logic [7:0]            c_SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] c_AN_OFF  = AN_ACT_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    if (SCAN_DIV < BLANK_CYC + 2**PWM_BITS) begin : g_bad_timing
        $error("seg7_scan_ctrl: SCAN_DIV must be >= BLANK_CYC + 2**PWM_BITS");
    end
    if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_bad_digits
        $error("seg7_scan_ctrl: NUM_DIGITS must be within 2..16");
    end

    logic [c_CW-1:0]       slot_cnt_q, slot_cnt_d;
    logic [c_IW-1:0]       idx_q, idx_d;
    logic [3:0]            snap_nib_q;
    logic                  snap_dp_q;
    logic                  snap_dark_q;
    logic [PWM_BITS-1:0]   snap_bri_q;
    logic                  tick_pend_q;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_q;

    logic                  w_slot_start, w_slot_last, w_idx_last, w_upper_zero;
    logic [3:0]            w_live_nib, w_nib;
    logic                  w_live_dp, w_live_dark, w_dp, w_dark, w_lit;
    logic [PWM_BITS-1:0]   w_bri, w_pwm;
    logic [7:0]            w_seg_act;
    logic [NUM_DIGITS-1:0] w_an_act;

    function automatic logic [6:0] font7(input logic [3:0] n);
        case (n)
            4'h0: font7 = 7'h3F;  4'h1: font7 = 7'h06;  4'h2: font7 = 7'h5B;  4'h3: font7 = 7'h4F;
            4'h4: font7 = 7'h66;  4'h5: font7 = 7'h6D;  4'h6: font7 = 7'h7D;  4'h7: font7 = 7'h07;
            4'h8: font7 = 7'h7F;  4'h9: font7 = 7'h6F;  4'hA: font7 = 7'h77;  4'hB: font7 = 7'h7C;
            4'hC: font7 = 7'h39;  4'hD: font7 = 7'h5E;  4'hE: font7 = 7'h79;  default: font7 = 7'h71;
        endcase
    endfunction

    assign w_slot_start = (slot_cnt_q == '0);
    assign w_slot_last  = (slot_cnt_q == c_CW'(SCAN_DIV - 1));
    assign w_idx_last   = (idx_q == c_IW'(NUM_DIGITS - 1));
    assign slot_cnt_d   = w_slot_last ? '0 : slot_cnt_q + c_CW'(1);
    assign idx_d        = !w_slot_last ? idx_q : (w_idx_last ? '0 : idx_q + c_IW'(1));

    // Leading zero: this digit and every more-significant digit hold zero.
    always_comb begin
        w_upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx_q) && digits_i[4*k +: 4] != 4'h0) begin
                w_upper_zero = 1'b0;
            end
        end
    end

    assign w_live_nib  = digits_i[4*idx_q +: 4];
    assign w_live_dp   = dp_mask[idx_q];
    assign w_live_dark = blank_mask[idx_q] | (blink_mask[idx_q] & blink_phase)
                       | (lz_en & (idx_q != '0) & w_upper_zero);

    // The first cycle of a slot uses the live values the snapshot is taking.
    assign w_nib  = w_slot_start ? w_live_nib  : snap_nib_q;
    assign w_dp   = w_slot_start ? w_live_dp   : snap_dp_q;
    assign w_dark = w_slot_start ? w_live_dark : snap_dark_q;
    assign w_bri  = w_slot_start ? brightness  : snap_bri_q;
    assign w_pwm  = slot_cnt_q[PWM_BITS-1:0];

    assign w_lit     = (slot_cnt_q >= c_CW'(BLANK_CYC)) & ~w_dark
                     & ((w_bri == '1) | (w_pwm < w_bri));
    assign w_seg_act = w_lit ? {w_dp, font7(w_nib)} : 8'h00;
    assign w_an_act  = w_lit ? (NUM_DIGITS'(1) << idx_q) : '0;
    assign seg_d     = SEG_ACT_LOW ? ~w_seg_act : w_seg_act;
    assign an_d      = AN_ACT_LOW  ? ~w_an_act  : w_an_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q  <= '0;
            idx_q       <= '0;
            snap_nib_q  <= '0;
            snap_dp_q   <= 1'b0;
            snap_dark_q <= 1'b1;
            snap_bri_q  <= '0;
            tick_pend_q <= 1'b0;
            seg_q       <= c_SEG_OFF;
            an_q        <= c_AN_OFF;
            frame_q     <= 1'b0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            idx_q       <= idx_d;
            if (w_slot_start) begin
                snap_nib_q  <= w_live_nib;
                snap_dp_q   <= w_live_dp;
                snap_dark_q <= w_live_dark;
                snap_bri_q  <= brightness;
            end
            // Delay one cycle so the pulse lines up with digit 0's first output.
            tick_pend_q <= w_slot_last & w_idx_last;
            frame_q     <= tick_pend_q;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign frame_tick = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Purpose  : Self-checking bench for seg7_scan_ctrl (4 digits, 32-cycle slots).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int N = 4, DIV = 32, BLANK = 4, FRAME = N * DIV;
    localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [15:0] digits_i = '0;
    logic [3:0]  dp_mask = '0, blank_mask = '0, blink_mask = '0;
    logic        blink_phase = 1'b0, lz_en = 1'b0;
    logic [1:0]  brightness = 2'd3;
    logic [7:0]  seg_out;
    logic [3:0]  an_out;
    logic        frame_tick;

    int checks = 0, errors = 0;
    int s = 0;
    logic [3:0] snap_nib;
    logic       snap_dp, snap_dark;
    logic [1:0] snap_bri;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic       exp_ft;

    seg7_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .BLANK_CYC(BLANK), .PWM_BITS(2),
                     .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .digits_i(digits_i), .dp_mask(dp_mask),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .blink_phase(blink_phase),
        .lz_en(lz_en), .brightness(brightness), .seg_out(seg_out), .an_out(an_out),
        .frame_tick(frame_tick));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: step s is the s-th clock edge after reset release;
    // the outputs after that edge describe slot position s mod 32 of digit (s/32) mod 4.
    task automatic tick();
        int  slot, idx;
        logic on;
        slot = s % DIV;
        idx  = (s / DIV) % N;
        if (slot == 0) begin
            snap_nib  = digits_i[4*idx +: 4];
            snap_dp   = dp_mask[idx];
            snap_dark = blank_mask[idx] | (blink_mask[idx] & blink_phase)
                      | (lz_en && idx != 0 && (digits_i >> (4*idx)) == 16'h0);
            snap_bri  = brightness;
        end
        on      = (slot >= BLANK) && !snap_dark && (snap_bri == 2'd3 || (slot % 4) < snap_bri);
        exp_an  = on ? ~(4'b0001 << idx) : 4'hF;
        exp_seg = on ? ~{snap_dp, FONT[snap_nib]} : 8'hFF;
        exp_ft  = (s > 0) && (s % FRAME == 0);
        @(posedge clk);
        #1;
        s++;
    endtask

    task automatic align(int phase);
        while (s % FRAME != phase) tick();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        s = 0;
    endtask

    function automatic int lit_digit(logic [3:0] an);
        lit_digit = -1;
        for (int k = 0; k < N; k++) if (!an[k]) lit_digit = k;
    endfunction

    task automatic test_reset();
        #12;
        checks++;
        if (an_out !== 4'hF || seg_out !== 8'hFF || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: an=%h seg=%h ft=%b, want an=F seg=FF ft=0", an_out, seg_out, frame_tick);
        end
    endtask

    task automatic test_basic();
        digits_i = 16'h1234; brightness = 2'd3;
        release_reset();
        for (int e = 1; e <= 64; e++) begin
            tick();
            checks++;
            if (an_out !== exp_an || seg_out !== exp_seg || frame_tick !== exp_ft) begin
                errors++;
                $display("FAIL basic_model e=%0d: an=%h seg=%h ft=%b, want an=%h seg=%h ft=%b",
                         e, an_out, seg_out, frame_tick, exp_an, exp_seg, exp_ft);
            end
            if (e <= 4 || e == 33) begin
                checks++;
                if (an_out !== 4'hF || seg_out !== 8'hFF) begin
                    errors++;
                    $display("FAIL basic_blank e=%0d: an=%h seg=%h, want F/FF", e, an_out, seg_out);
                end
            end
            if (e == 5 || e == 32) begin
                checks++;
                if (an_out !== 4'b1110 || seg_out !== 8'h99) begin
                    errors++;
                    $display("FAIL basic_digit0 e=%0d: an=%b seg=%h, want 1110/99", e, an_out, seg_out);
                end
            end
            if (e == 37) begin
                checks++;
                if (an_out !== 4'b1101 || seg_out !== 8'hB0) begin
                    errors++;
                    $display("FAIL basic_digit1 e=%0d: an=%b seg=%h, want 1101/B0", e, an_out, seg_out);
                end
            end
        end
    endtask

    task automatic test_frame();
        int last = -1;
        for (int c = 0; c < 3 * FRAME + 8; c++) begin
            tick();
            checks++;
            if (frame_tick !== exp_ft || an_out !== exp_an) begin
                errors++;
                $display("FAIL frame_model s=%0d: ft=%b an=%h, want ft=%b an=%h", s, frame_tick, an_out, exp_ft, exp_an);
            end
            checks++;
            if (!$onehot0(~an_out)) begin
                errors++;
                $display("FAIL anode_onehot s=%0d: an=%b, want one-hot low or 1111", s, an_out);
            end
            if (frame_tick === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (s - last != FRAME) begin
                        errors++;
                        $display("FAIL frame_period: got %0d, want %0d", s - last, FRAME);
                    end
                end
                last = s;
            end
        end
        checks++;
        if (last < 0) begin
            errors++;
            $display("FAIL frame_seen: got none, want periodic frame_tick");
        end
    endtask

    task automatic test_pwm();
        int cnt;
        brightness = 2'd1;
        align(0);
        cnt = 0;
        for (int c = 0; c < FRAME; c++) begin
            tick();
            if (an_out !== 4'hF) cnt++;
            checks++;
            if (an_out !== exp_an || seg_out !== exp_seg) begin
                errors++;
                $display("FAIL pwm1_model s=%0d: an=%h seg=%h, want %h/%h", s, an_out, seg_out, exp_an, exp_seg);
            end
        end
        checks++;
        if (cnt != 4 * 7) begin
            errors++;
            $display("FAIL pwm1_duty: lit cycles %0d, want 28", cnt);
        end
        brightness = 2'd0;
        align(0);
        cnt = 0;
        for (int c = 0; c < FRAME; c++) begin
            tick();
            if (an_out !== 4'hF) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("FAIL pwm0_dark: lit cycles %0d, want 0", cnt);
        end
        brightness = 2'd3;
    endtask

    task automatic test_lz();
        logic [3:0] lit;
        logic [7:0] seen [N];
        lz_en = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            digits_i = (pass == 0) ? 16'h0070 : 16'h0000;
            align(0);
            lit = '0;
            for (int k = 0; k < N; k++) seen[k] = 8'hFF;
            for (int c = 0; c < FRAME; c++) begin
                tick();
                if (lit_digit(an_out) >= 0) begin
                    lit[lit_digit(an_out)] = 1'b1;
                    seen[lit_digit(an_out)] = seg_out;
                end
                checks++;
                if (an_out !== exp_an || seg_out !== exp_seg) begin
                    errors++;
                    $display("FAIL lz_model s=%0d: an=%h seg=%h, want %h/%h", s, an_out, seg_out, exp_an, exp_seg);
                end
            end
            checks++;
            if (lit !== ((pass == 0) ? 4'b0011 : 4'b0001) || seen[0] !== 8'hC0 ||
                (pass == 0 && seen[1] !== 8'hF8)) begin
                errors++;
                $display("FAIL lz_digits pass=%0d: lit=%b seg0=%h seg1=%h, want lit=%b seg0=C0 seg1=%s",
                         pass, lit, seen[0], seen[1], (pass == 0) ? 4'b0011 : 4'b0001, (pass == 0) ? "F8" : "-");
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_blink();
        int lit01;
        digits_i = 16'h5A3C; blink_mask = 4'b0011; blink_phase = 1'b1; dp_mask = 4'b0100;
        align(0);
        lit01 = 0;
        for (int c = 0; c < FRAME; c++) begin
            tick();
            if (an_out[0] === 1'b0 || an_out[1] === 1'b0) lit01++;
            if (an_out === 4'b1011) begin
                checks++;
                if (seg_out !== {1'b0, ~FONT[4'hA]}) begin
                    errors++;
                    $display("FAIL blink_dp2: seg=%h, want %h", seg_out, {1'b0, ~FONT[4'hA]});
                end
            end
        end
        checks++;
        if (lit01 != 0) begin
            errors++;
            $display("FAIL blink_dark01: lit cycles %0d, want 0", lit01);
        end
        blink_mask = 4'b0111;
        align(2 * DIV + 12);
        blink_phase = 1'b0;
        for (int c = 0; c < 2 * DIV; c++) begin
            tick();
            if (c < DIV - 12) begin
                checks++;
                if (an_out !== 4'hF) begin
                    errors++;
                    $display("FAIL blink_no_tear s=%0d: an=%b, want 1111", s, an_out);
                end
            end
            checks++;
            if (an_out !== exp_an || seg_out !== exp_seg) begin
                errors++;
                $display("FAIL blink_model s=%0d: an=%h seg=%h, want %h/%h", s, an_out, seg_out, exp_an, exp_seg);
            end
        end
        blink_mask = '0; dp_mask = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 6 * FRAME; c++) begin
            case ($urandom_range(0, 15))
                0: digits_i    = 16'($urandom);
                1: dp_mask     = 4'($urandom);
                2: blank_mask  = 4'($urandom) & 4'($urandom);
                3: blink_mask  = 4'($urandom);
                4: blink_phase = ~blink_phase;
                5: lz_en       = 1'($urandom);
                6: brightness  = 2'($urandom);
                default: ;
            endcase
            tick();
            checks++;
            if (an_out !== exp_an || seg_out !== exp_seg || frame_tick !== exp_ft) begin
                errors++;
                $display("FAIL random_model s=%0d: an=%h seg=%h ft=%b, want an=%h seg=%h ft=%b",
                         s, an_out, seg_out, frame_tick, exp_an, exp_seg, exp_ft);
            end
        end
        digits_i = 16'h9876; dp_mask = '0; blank_mask = '0; blink_mask = '0;
        lz_en = 1'b0; brightness = 2'd3;
    endtask

    task automatic test_async_reset();
        align(0);
        align(2 * DIV + 10);
        tick();
        checks++;
        if (an_out !== 4'b1011) begin
            errors++;
            $display("FAIL areset_pre: an=%b, want 1011", an_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (an_out !== 4'hF || seg_out !== 8'hFF || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL areset_now: an=%h seg=%h ft=%b, want F/FF/0", an_out, seg_out, frame_tick);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (an_out !== 4'hF || seg_out !== 8'hFF) begin
            errors++;
            $display("FAIL areset_hold: an=%h seg=%h, want F/FF", an_out, seg_out);
        end
        release_reset();
        for (int e = 1; e <= 40; e++) begin
            tick();
            checks++;
            if (an_out !== exp_an || seg_out !== exp_seg || frame_tick !== exp_ft) begin
                errors++;
                $display("FAIL areset_restart e=%0d: an=%h seg=%h ft=%b, want an=%h seg=%h ft=%b",
                         e, an_out, seg_out, frame_tick, exp_an, exp_seg, exp_ft);
            end
            if (e == 5) begin
                checks++;
                if (an_out !== 4'b1110 || seg_out !== ~{1'b0, FONT[4'h6]}) begin
                    errors++;
                    $display("FAIL areset_digit0: an=%b seg=%h, want 1110/%h", an_out, seg_out, ~{1'b0, FONT[4'h6]});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame();
        test_pwm();
        test_lz();
        test_blink();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
